// File: rtl/mem_dma_if.sv
// Register-port and initiator-bus bundles for the mem_dma word-copy engine.
`timescale 1ns/1ps

interface mem_reg_if;
  logic        mem_sel;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wr;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_sel, mem_valid, mem_wr, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_sel, mem_valid, mem_wr, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

interface mem_bus_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/mem_dma.sv
// Word-copy DMA: one read then one write per word, requests held until m_ready.
// Register port answers one cycle after a request; irq only exists with MEM_DMA_IRQ_EN.
`timescale 1ns/1ps

module mem_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic       clk,
  input  logic       reset_,
  mem_reg_if.slave   regs,
  mem_bus_if.master  bus,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t              state;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] len;
  logic [31:0]         data_buf;
  logic                done;
  logic                start_pend;
  logic                mem_ready_q;
  logic [31:0]         mem_rdata_q;
  logic                m_valid_q;
  logic [31:0]         m_addr_q;
  logic [3:0]          m_wstrb_q;
  logic                irq_en_bit;

  logic                req;
  logic                wr_req;
  logic                busy;
  logic [3:0]          off;
  logic [31:0]         rd_val;
  logic                unused_addr_hi;

  assign off            = regs.mem_addr[3:0];
  assign unused_addr_hi = ^regs.mem_addr[11:4];
  assign req            = regs.mem_valid & regs.mem_sel & ~mem_ready_q;
  assign wr_req         = req & regs.mem_wr;
  // The start-pending cycle counts as busy so a racing write cannot alter the job being launched.
  assign busy           = (state != IDLE) | start_pend;

  assign regs.mem_ready = mem_ready_q;
  assign regs.mem_rdata = mem_rdata_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_wdata    = data_buf;
  assign bus.m_wstrb    = m_wstrb_q;

  always_comb begin
    rd_val = 32'h0;
    case (off)
      4'h0: rd_val = src;
      4'h4: rd_val = dst;
      4'h8: rd_val = 32'(len);
      4'hC: rd_val = {28'h0, irq_en_bit, done, busy, 1'b0};
      default: rd_val = 32'h0;
    endcase
  end

`ifdef MEM_DMA_IRQ_EN
  logic irq_en_q;
  logic irq_q;
  assign irq_en_bit = irq_en_q;
  assign irq        = irq_q;
`else
  logic unused_wdata3;
  assign unused_wdata3 = regs.mem_wdata[3];
  assign irq_en_bit    = 1'b0;
  assign irq           = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      src         <= 32'h0;
      dst         <= 32'h0;
      len         <= '0;
      data_buf    <= 32'h0;
      done        <= 1'b0;
      start_pend  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= 32'h0;
      m_wstrb_q   <= 4'h0;
`ifdef MEM_DMA_IRQ_EN
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      mem_ready_q <= req;
      mem_rdata_q <= req ? rd_val : 32'h0;
      start_pend  <= 1'b0;
`ifdef MEM_DMA_IRQ_EN
      irq_q       <= done & irq_en_q;
`endif

      if (wr_req) begin
        case (off)
          4'h0: if (!busy) src <= {regs.mem_wdata[31:2], 2'b00};
          4'h4: if (!busy) dst <= {regs.mem_wdata[31:2], 2'b00};
          4'h8: if (!busy) len <= regs.mem_wdata[LEN_BITS-1:0];
          4'hC: begin
            if (!busy && regs.mem_wdata[0]) start_pend <= 1'b1;
            if (regs.mem_wdata[2]) done <= 1'b0;
`ifdef MEM_DMA_IRQ_EN
            irq_en_q <= regs.mem_wdata[3];
`endif
          end
          default: ;
        endcase
      end

      // Engine updates come after the software writes so an engine-set DONE wins.
      case (state)
        IDLE: begin
          if (start_pend) begin
            if (len != '0) begin
              state     <= RD;
              done      <= 1'b0;
              m_valid_q <= 1'b1;
              m_addr_q  <= src;
              m_wstrb_q <= 4'h0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RD: begin
          if (bus.m_ready) begin
            data_buf  <= bus.m_rdata;
            m_addr_q  <= dst;
            m_wstrb_q <= 4'hF;
            state     <= WR;
          end
        end
        WR: begin
          if (bus.m_ready) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            len <= len - LEN_BITS'(1);
            if (len == LEN_BITS'(1)) begin
              state     <= IDLE;
              m_valid_q <= 1'b0;
              m_wstrb_q <= 4'h0;
              done      <= 1'b1;
            end else begin
              state     <= RD;
              m_addr_q  <= src + 32'd4;
              m_wstrb_q <= 4'h0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a negedge-driven RAM responder of configurable ready delay.
`timescale 1ns/1ps

module tb_mem_dma;

`ifdef MEM_DMA_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  logic reset_;
  logic irq;
  int   tests_run;
  int   failed;

  mem_reg_if rif ();
  mem_bus_if bif ();

  mem_dma #(.LEN_BITS(16)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .regs   (rif.slave),
    .bus    (bif.master),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder model state: written only by the responder process.
  logic [31:0] mem_arr [0:1023];
  bit          written [0:1023];
  logic [31:0] rd_log  [0:63];
  logic [31:0] wr_log  [0:63];
  int          n_rd, n_wr, stab_err, valid_cycles, cnt;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  int          resp_delay;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return written[a[11:2]] ? mem_arr[a[11:2]] : pat(a);
  endfunction

  initial begin
    n_rd = 0; n_wr = 0; stab_err = 0; valid_cycles = 0; cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      written[i] = 1'b0;
      mem_arr[i] = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!reset_) begin
      bif.m_ready = 1'b0;
      bif.m_rdata = 32'hDEAD_BEEF;
      cnt = 0;
    end else if (bif.m_ready) begin
      if (cur_wstrb == 4'hF) begin
        mem_arr[cur_addr[11:2]] = cur_wdata;
        written[cur_addr[11:2]] = 1'b1;
        wr_log[n_wr & 63] = cur_addr;
        n_wr++;
      end else begin
        rd_log[n_rd & 63] = cur_addr;
        n_rd++;
      end
      bif.m_ready = 1'b0;
      bif.m_rdata = 32'hDEAD_BEEF;
      cnt = 0;
    end else if (bif.m_valid) begin
      if (cnt == 0) begin
        cur_addr  = bif.m_addr;
        cur_wstrb = bif.m_wstrb;
        cur_wdata = bif.m_wdata;
      end else if (bif.m_addr !== cur_addr || bif.m_wstrb !== cur_wstrb ||
                   bif.m_wdata !== cur_wdata) begin
        stab_err++;
      end
      cnt++;
      if (cnt >= resp_delay) begin
        bif.m_ready = 1'b1;
        bif.m_rdata = ram_word(cur_addr);
      end
    end
    if (bif.m_valid === 1'b1) valid_cycles++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called just after a negedge; leaves the port idle for one cycle afterwards.
  task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
    rif.mem_sel = 1'b1; rif.mem_valid = 1'b1; rif.mem_wr = 1'b1;
    rif.mem_addr = a; rif.mem_wdata = d;
    @(posedge clk);
    step();
    rif.mem_sel = 1'b0; rif.mem_valid = 1'b0; rif.mem_wr = 1'b0;
    step();
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [31:0] d);
    rif.mem_sel = 1'b1; rif.mem_valid = 1'b1; rif.mem_wr = 1'b0;
    rif.mem_addr = a; rif.mem_wdata = 32'h0;
    @(posedge clk);
    step();
    d = rif.mem_rdata;
    rif.mem_sel = 1'b0; rif.mem_valid = 1'b0;
    step();
  endtask

  task automatic wait_done(input string name);
    logic [31:0] d;
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      reg_read(12'hC, d);
      if (d[2]) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin
      failed++;
      $display("FAIL %s_done_timeout got ctrl=%h required DONE=1", name, d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_r [4];
    reset_ = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bif.m_valid !== 1'b0 || bif.m_addr !== 32'h0 || bif.m_wdata !== 32'h0 ||
        bif.m_wstrb !== 4'h0 || rif.mem_ready !== 1'b0 || rif.mem_rdata !== 32'h0 || irq !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs got v=%b a=%h d=%h s=%h rdy=%b rd=%h irq=%b required all 0",
               bif.m_valid, bif.m_addr, bif.m_wdata, bif.m_wstrb, rif.mem_ready, rif.mem_rdata, irq);
    end
    reset_ = 1'b1;
    step();
    exp_r = '{32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      reg_read(12'(i * 4), d);
      tests_run++;
      if (d !== exp_r[i]) begin
        failed++;
        $display("FAIL reset_reg%0d got %h required %h", i, d, exp_r[i]);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    reg_write(12'h0, 32'h0000_0123);
    reg_write(12'h4, 32'hFFFF_FFFF);
    reg_write(12'h8, 32'h0001_2345);
    reg_write(12'hC, 32'h0000_0008);
    reg_write(12'h6, 32'hFFFF_FFFF);
    reg_read(12'h0, d);
    tests_run++;
    if (d !== 32'h0000_0120) begin failed++; $display("FAIL regs_src_align got %h required %h", d, 32'h120); end
    reg_read(12'h4, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFC) begin failed++; $display("FAIL regs_dst_align got %h required %h", d, 32'hFFFFFFFC); end
    reg_read(12'h8, d);
    tests_run++;
    if (d !== 32'h0000_2345) begin failed++; $display("FAIL regs_len_width got %h required %h", d, 32'h2345); end
    reg_read(12'hC, d);
    tests_run++;
    if (d !== 32'({IRQ_ON, 3'b000})) begin failed++; $display("FAIL regs_ctrl_irqen got %h required %h", d, 32'({IRQ_ON, 3'b000})); end
    reg_read(12'h6, d);
    tests_run++;
    if (d !== 32'h0) begin failed++; $display("FAIL regs_hole got %h required 0", d); end
    reg_read(12'h100, d);
    tests_run++;
    if (d !== 32'h0000_0120) begin failed++; $display("FAIL regs_alias got %h required %h", d, 32'h120); end
    reg_write(12'hC, 32'h0);
  endtask

  task automatic check_copy(input string name, input logic [31:0] s, input logic [31:0] t,
                            input int n, input int b_rd, input int b_wr);
    tests_run++;
    if (n_rd - b_rd != n || n_wr - b_wr != n) begin
      failed++;
      $display("FAIL %s_count got rd=%0d wr=%0d required %0d each", name, n_rd - b_rd, n_wr - b_wr, n);
    end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (rd_log[(b_rd + i) & 63] !== s + 32'(4 * i) || wr_log[(b_wr + i) & 63] !== t + 32'(4 * i) ||
          mem_arr[(t + 32'(4 * i)) >> 2 & 32'h3FF] !== pat(s + 32'(4 * i))) begin
        failed++;
        $display("FAIL %s_word%0d got rd@%h wr@%h data %h required rd@%h wr@%h data %h", name, i,
                 rd_log[(b_rd + i) & 63], wr_log[(b_wr + i) & 63], mem_arr[(t + 32'(4 * i)) >> 2 & 32'h3FF],
                 s + 32'(4 * i), t + 32'(4 * i), pat(s + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_copy();
    logic [31:0] d;
    int b_rd, b_wr;
    resp_delay = 1;
    reg_write(12'hC, 32'h4);
    reg_write(12'h0, 32'h100);
    reg_write(12'h4, 32'h200);
    reg_write(12'h8, 32'd4);
    b_rd = n_rd; b_wr = n_wr;
    reg_write(12'hC, 32'h1);
    wait_done("copy");
    check_copy("copy", 32'h100, 32'h200, 4, b_rd, b_wr);
    reg_read(12'h8, d);
    tests_run++;
    if (d !== 32'h0) begin failed++; $display("FAIL copy_len got %h required 0", d); end
    reg_read(12'h0, d);
    tests_run++;
    if (d !== 32'h110) begin failed++; $display("FAIL copy_src got %h required 110", d); end
    reg_read(12'h4, d);
    tests_run++;
    if (d !== 32'h210) begin failed++; $display("FAIL copy_dst got %h required 210", d); end
    reg_read(12'hC, d);
    tests_run++;
    if (d !== 32'h4) begin failed++; $display("FAIL copy_ctrl got %h required 4", d); end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    int b_v;
    reg_write(12'hC, 32'h4);
    reg_write(12'h8, 32'h0);
    b_v = valid_cycles;
    reg_write(12'hC, 32'h1);
    reg_read(12'hC, d);
    reg_read(12'hC, d);
    tests_run++;
    if (d !== 32'h4) begin failed++; $display("FAIL zero_len_done got %h required 4", d); end
    repeat (5) step();
    tests_run++;
    if (valid_cycles != b_v) begin failed++; $display("FAIL zero_len_no_bus got %0d valid cycles required 0", valid_cycles - b_v); end
  endtask

  task automatic test_slow_responder();
    int b_rd, b_wr, b_s;
    resp_delay = 3;
    reg_write(12'hC, 32'h4);
    reg_write(12'h0, 32'h300);
    reg_write(12'h4, 32'h400);
    reg_write(12'h8, 32'd2);
    b_rd = n_rd; b_wr = n_wr; b_s = stab_err;
    reg_write(12'hC, 32'h1);
    wait_done("slow");
    tests_run++;
    if (stab_err != b_s) begin failed++; $display("FAIL slow_stable got %0d changes required 0", stab_err - b_s); end
    check_copy("slow", 32'h300, 32'h400, 2, b_rd, b_wr);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int b_rd, b_wr;
    resp_delay = 1;
    reg_write(12'hC, 32'h4);
    reg_write(12'h0, 32'hFFFF_FFFC);
    reg_write(12'h4, 32'h500);
    reg_write(12'h8, 32'd2);
    b_rd = n_rd; b_wr = n_wr;
    reg_write(12'hC, 32'h1);
    wait_done("wrap");
    check_copy("wrap", 32'hFFFF_FFFC, 32'h500, 2, b_rd, b_wr);
    reg_read(12'h0, d);
    tests_run++;
    if (d !== 32'h4) begin failed++; $display("FAIL wrap_src got %h required 4", d); end
  endtask

  task automatic test_busy_writes();
    logic [31:0] d;
    int b_rd, b_wr;
    bit hit;
    resp_delay = 10;
    reg_write(12'hC, 32'h4);
    reg_write(12'h0, 32'h600);
    reg_write(12'h4, 32'h900);
    reg_write(12'h8, 32'd2);
    b_rd = n_rd; b_wr = n_wr;
    reg_write(12'hC, 32'h9);
    reg_write(12'h0, 32'h0);
    reg_write(12'h8, 32'h0);
    reg_read(12'h0, d);
    tests_run++;
    if (d !== 32'h600) begin failed++; $display("FAIL busy_src_locked got %h required 600", d); end
    reg_read(12'hC, d);
    tests_run++;
    if (d !== 32'({IRQ_ON, 3'b010})) begin failed++; $display("FAIL busy_ctrl got %h required %h", d, 32'({IRQ_ON, 3'b010})); end
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bif.m_ready === 1'b1 && bif.m_wstrb === 4'hF && n_wr == b_wr + 1) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin failed++; $display("FAIL busy_last_write_timeout got none required final write handshake"); end
    // DONE clear lands on the same edge as the final write handshake.
    reg_write(12'hC, 32'hC);
    reg_read(12'hC, d);
    tests_run++;
    if (d !== 32'({IRQ_ON, 3'b100})) begin failed++; $display("FAIL busy_done_wins got %h required %h", d, 32'({IRQ_ON, 3'b100})); end
    check_copy("busy", 32'h600, 32'h900, 2, b_rd, b_wr);
    repeat (2) step();
    tests_run++;
    if (irq !== IRQ_ON) begin failed++; $display("FAIL irq_set got %b required %b", irq, IRQ_ON); end
    reg_write(12'hC, 32'hC);
    repeat (2) step();
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL irq_clear got %b required 0", irq); end
    reg_write(12'hC, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int b_v, b_rd;
    bit hit;
    resp_delay = 3;
    reg_write(12'hC, 32'h4);
    reg_write(12'h0, 32'h700);
    reg_write(12'h4, 32'h800);
    reg_write(12'h8, 32'd8);
    reg_write(12'hC, 32'h1);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bif.m_valid === 1'b1 && bif.m_wstrb === 4'hF) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin failed++; $display("FAIL rst_mid_wr_timeout got none required WR phase"); end
    reset_ = 1'b0;
    #1;
    tests_run++;
    if (bif.m_valid !== 1'b0 || bif.m_addr !== 32'h0 || bif.m_wstrb !== 4'h0 || bif.m_wdata !== 32'h0) begin
      failed++;
      $display("FAIL rst_mid_bus got v=%b a=%h s=%h d=%h required 0", bif.m_valid, bif.m_addr, bif.m_wstrb, bif.m_wdata);
    end
    repeat (2) step();
    reset_ = 1'b1;
    b_v = valid_cycles; b_rd = n_rd;
    repeat (20) step();
    tests_run++;
    if (valid_cycles != b_v || n_rd != b_rd) begin
      failed++;
      $display("FAIL rst_mid_quiet got %0d valid cycles required 0", valid_cycles - b_v);
    end
    for (int i = 0; i < 4; i++) begin
      reg_read(12'(i * 4), d);
      tests_run++;
      if (d !== 32'h0) begin failed++; $display("FAIL rst_mid_reg%0d got %h required 0", i, d); end
    end
  endtask

  initial begin
    tests_run = 0; failed = 0; resp_delay = 1;
    reset_ = 1'b0;
    rif.mem_sel = 1'b0; rif.mem_valid = 1'b0; rif.mem_wr = 1'b0;
    rif.mem_addr = 12'h0; rif.mem_wdata = 32'h0;
    step();
    test_reset();
    test_regs();
    test_copy();
    test_zero_len();
    test_slow_responder();
    test_wrap();
    test_busy_writes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no completion required finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameter LEN_BITS, default 16: width of the transfer word count.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_  input  1  asynchronous active-low reset.
REQ-004 mem_sel  input  1  register-port select from the SoC address decoder.
REQ-005 mem_valid  input  1  register-port request valid.
REQ-006 mem_ready  output  1  register-port completion strobe.
REQ-007 mem_wr  input  1  register-port write (1) / read (0).
REQ-008 mem_addr  input  12  register-port byte address.
REQ-009 mem_wdata  input  32  register-port write data.
REQ-010 mem_rdata  output  32  register-port read data, valid while mem_ready=1.
REQ-011 m_valid  output  1  initiator request valid, held until m_ready.
REQ-012 m_ready  input  1  initiator completion from the responder.
REQ-013 m_addr  output  32  initiator byte address, always word aligned.
REQ-014 m_wdata  output  32  initiator write data.
REQ-015 m_wstrb  output  4  initiator byte strobes: 4'h0 read, 4'hf write.
REQ-016 m_rdata  input  32  initiator read data, sampled when m_valid and m_ready are both 1.
REQ-017 irq  output  1  done interrupt (see Configuration).

Function
REQ-018 Register map (mem_addr[3:0]): 0x0 SRC, 0x4 DST, 0x8 LEN (remaining words), 0xC CTRL; other offsets read 0, writes ignored.
REQ-019 SRC/DST bits[1:0] shall be forced to 0 and read back as 0; LEN is zero-extended on read.
REQ-020 CTRL: bit0 START (write 1 to start, reads 0), bit1 BUSY (read only), bit2 DONE (write 1 to clear), bit3 IRQ_EN (read/write).
REQ-021 Register-port mem_ready = registered (mem_valid & mem_sel & !mem_ready): one pulse, one cycle after request; write side effects on that request cycle only.
REQ-022 While BUSY=1, writes to SRC, DST, LEN and START are ignored; DONE and IRQ_EN writes still apply.
REQ-023 FSM states IDLE, RD, WR; BUSY=1 in RD and WR.
REQ-024 IDLE: START with LEN!=0 -> RD and clear DONE; START with LEN==0 -> set DONE next cycle, stay IDLE, no bus activity.
REQ-025 RD: m_valid=1, m_addr=SRC, m_wstrb=0; on m_ready capture m_rdata into a data buffer -> WR.
REQ-026 WR: m_valid=1, m_addr=DST, m_wstrb=4'hf, m_wdata=buffer; on m_ready SRC+=4, DST+=4, LEN-=1; -> IDLE with DONE=1 if LEN was 1, else -> RD.
REQ-027 m_addr/m_wdata/m_wstrb shall change only in the cycle after m_ready; m_valid may stay high across back-to-back requests.
REQ-028 SRC/DST increments wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x0).
REQ-029 Engine-set DONE wins over a simultaneous software DONE clear.
REQ-030 m_valid=0 in IDLE; m_rdata is ignored outside RD.

Reset
REQ-031 reset_ low asynchronously forces IDLE, SRC=DST=LEN=0, buffer=0, DONE=BUSY=IRQ_EN=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, mem_ready=0, mem_rdata=0, irq=0.
REQ-032 Reset mid-transfer shall abandon the transfer immediately; m_valid low from reset assertion, no completion on release.

Configuration
REQ-033 Macro MEM_DMA_IRQ_EN defined: irq = DONE & IRQ_EN, registered, level, cleared by DONE clear.
REQ-034 Macro MEM_DMA_IRQ_EN undefined: irq tied 0, CTRL bit3 reads 0 and ignores writes.

Verification
REQ-035 SRC=0x100, DST=0x200, LEN=4, START, 1-cycle-latency RAM model -> 4 read/write pairs, words copied to 0x200..0x20C, DONE=1, LEN=0, SRC=0x110, DST=0x210.
REQ-036 LEN=0, START -> no m_valid ever, DONE=1 two cycles after the START request.
REQ-037 Responder with 3-cycle ready delay, LEN=2 -> m_addr/m_wstrb stable while m_valid & !m_ready, copy correct.
REQ-038 SRC=0xFFFFFFFC, LEN=2 -> second read at m_addr=0x0.
REQ-039 Write SRC=0x0 while BUSY -> SRC unchanged; DONE W1C on the completing cycle -> DONE=1; with MEM_DMA_IRQ_EN and IRQ_EN=1, irq=1.
REQ-040 reset_ low during WR of LEN=8 -> m_valid=0 immediately, all registers 0, no further bus requests after release.
